// File: rtl/mano_io_pkg.sv
// mano_io_pkg
// Shared definitions for the Mano machine character I/O controller:
// output-channel FSM states, IR bit positions of the register-I/O
// instructions and the default character width.
package mano_io_pkg;

  localparam int DATA_W_DEF = 8;

  // Bit positions inside IR[11:0] for register-I/O instructions
  localparam int IR_INP = 11;
  localparam int IR_OUT = 10;
  localparam int IR_SKI = 9;
  localparam int IR_SKO = 8;
  localparam int IR_ION = 7;
  localparam int IR_IOF = 6;

  // Output channel: IDLE means OUTR is free (FGO=1), SEND means a
  // character is being offered to the output device
  typedef enum logic {
    OST_IDLE = 1'b0,
    OST_SEND = 1'b1
  } ost_e;

endpackage

// File: rtl/mano_io_fifo.sv
// mano_io_fifo
// Small synchronous FIFO that buffers characters from the input device
// behind INPR.  The head entry is visible combinationally.
//
// Ports:
//   clock      in   rising-edge clock
//   reset      in   synchronous active-high reset (empties the FIFO)
//   push       in   write push_data this cycle (ignored when full)
//   push_data  in   DATA_W character to store
//   pop        in   drop the head entry this cycle (ignored when empty)
//   head       out  oldest stored character
//   full       out  all DEPTH entries occupied
//   empty      out  no entries stored
module mano_io_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;
  logic              push_ok;
  logic              pop_ok;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Storage is cleared on reset so the head reads as zero while empty.
  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mano_io_ctrl.sv
// mano_io_ctrl
// Character I/O controller for the Mano machine.  Owns INPR/OUTR, the
// FGI/FGO/IEN flags and the interrupt request, and runs valid/ready
// handshakes towards the input and output character devices.
//
// Build option: define MANO_IO_INFIFO_EN to place a FIFO_DEPTH-entry
// input FIFO behind INPR (FGI = FIFO not empty, INP pops).  Without it
// INPR is a single register guarded by FGI.
//
// Ports:
//   io_clock, io_reset          clock, synchronous active-high reset
//   io_iostb                    register-I/O instruction executes now
//   io_ir[11:0]                 INP/OUT/SKI/SKO/ION/IOF decode bits
//   io_ac                       accumulator character, source for OUT
//   io_int_ack                  CPU entered interrupt cycle, clears IEN
//   io_inpr                     current input character
//   io_skip                     skip condition for SKI/SKO (combinational)
//   io_fgi, io_fgo, io_ien      flag registers
//   io_irq                      interrupt request (combinational)
//   io_outr                     OUTR register
//   io_din_valid/data/ready     input device channel
//   io_dout_valid/data/ready    output device channel
module mano_io_ctrl
  import mano_io_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              io_clock,
  input  logic              io_reset,
  input  logic              io_iostb,
  input  logic [11:0]       io_ir,
  input  logic [DATA_W-1:0] io_ac,
  input  logic              io_int_ack,
  output logic [DATA_W-1:0] io_inpr,
  output logic              io_skip,
  output logic              io_fgi,
  output logic              io_fgo,
  output logic              io_ien,
  output logic              io_irq,
  output logic [DATA_W-1:0] io_outr,
  input  logic              io_din_valid,
  input  logic [DATA_W-1:0] io_din_data,
  output logic              io_din_ready,
  output logic              io_dout_valid,
  output logic [DATA_W-1:0] io_dout_data,
  input  logic              io_dout_ready
);

  logic do_inp;
  logic do_out;
  logic do_ion;
  logic do_iof;
  logic fgi;
  logic fgo;
  logic ien;
  logic unused_ir;

  assign do_inp    = io_iostb & io_ir[IR_INP];
  assign do_out    = io_iostb & io_ir[IR_OUT];
  assign do_ion    = io_iostb & io_ir[IR_ION];
  assign do_iof    = io_iostb & io_ir[IR_IOF];
  assign unused_ir = ^io_ir[5:0];

  // ---------------------------------------------------------------
  // Output channel
  // ---------------------------------------------------------------
  ost_e              ost_state;
  ost_e              ost_next;
  logic [DATA_W-1:0] outr;
  logic [DATA_W-1:0] outr_next;

  always_ff @(posedge io_clock) begin
    if (io_reset) begin
      ost_state <= OST_IDLE;
      outr      <= '0;
    end else begin
      ost_state <= ost_next;
      outr      <= outr_next;
    end
  end

  // FGO is simply "channel idle".  An OUT arriving during SEND is
  // dropped so the character on the wire stays stable.
  always_comb begin
    ost_next      = ost_state;
    outr_next     = outr;
    fgo           = 1'b0;
    io_dout_valid = 1'b0;
    case (ost_state)
      OST_IDLE: begin
        fgo = 1'b1;
        if (do_out) begin
          outr_next = io_ac;
          ost_next  = OST_SEND;
        end
      end
      OST_SEND: begin
        io_dout_valid = 1'b1;
        if (io_dout_ready) begin
          ost_next = OST_IDLE;
        end
      end
      default: begin
        ost_next = OST_IDLE;
      end
    endcase
  end

  assign io_outr      = outr;
  assign io_dout_data = outr;

  // ---------------------------------------------------------------
  // Interrupt enable: int_ack beats IOF, IOF beats ION
  // ---------------------------------------------------------------
  always_ff @(posedge io_clock) begin
    if (io_reset) begin
      ien <= 1'b0;
    end else if (io_int_ack) begin
      ien <= 1'b0;
    end else if (do_iof) begin
      ien <= 1'b0;
    end else if (do_ion) begin
      ien <= 1'b1;
    end
  end

  // ---------------------------------------------------------------
  // Input channel
  // ---------------------------------------------------------------
`ifdef MANO_IO_INFIFO_EN
  logic fifo_full;
  logic fifo_empty;

  mano_io_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clock     (io_clock),
    .reset     (io_reset),
    .push      (io_din_valid & ~fifo_full),
    .push_data (io_din_data),
    .pop       (do_inp),
    .head      (io_inpr),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign io_din_ready = ~fifo_full;
  assign fgi          = ~fifo_empty;
`else
  localparam int unused_fifo_depth = FIFO_DEPTH;

  logic [DATA_W-1:0] inpr;

  // Acceptance is only possible while FGI=0, and INP with FGI=0 is a
  // no-op, so letting acceptance win a same-cycle INP is safe.
  always_ff @(posedge io_clock) begin
    if (io_reset) begin
      fgi  <= 1'b0;
      inpr <= '0;
    end else if (io_din_valid & ~fgi) begin
      fgi  <= 1'b1;
      inpr <= io_din_data;
    end else if (do_inp) begin
      fgi  <= 1'b0;
    end
  end

  assign io_din_ready = ~fgi;
  assign io_inpr      = inpr;
`endif

  // ---------------------------------------------------------------
  // Flags, skip and interrupt request
  // ---------------------------------------------------------------
  assign io_fgi  = fgi;
  assign io_fgo  = fgo;
  assign io_ien  = ien;
  assign io_skip = io_iostb & ((io_ir[IR_SKI] & fgi) | (io_ir[IR_SKO] & fgo));
  assign io_irq  = ien & (fgi | fgo);

endmodule

// File: tb/tb_mano_io_ctrl.sv
// tb_mano_io_ctrl
// Self-checking bench for mano_io_ctrl.  A vector table covers the
// single-cycle skip/IEN behaviour; hand-written sequences cover output
// transfers, input acceptance, interrupts, reset mid-transfer and (when
// MANO_IO_INFIFO_EN is defined) the input FIFO.  Characters are pushed
// to scoreboard queues when driven and compared when the DUT offers them.
module tb_mano_io_ctrl;
  import mano_io_pkg::*;

  localparam logic [11:0] B_INP = 12'h800;
  localparam logic [11:0] B_OUT = 12'h400;
  localparam logic [11:0] B_SKI = 12'h200;
  localparam logic [11:0] B_SKO = 12'h100;
  localparam logic [11:0] B_ION = 12'h080;
  localparam logic [11:0] B_IOF = 12'h040;

  logic        io_clock;
  logic        io_reset;
  logic        io_iostb;
  logic [11:0] io_ir;
  logic [7:0]  io_ac;
  logic        io_int_ack;
  logic [7:0]  io_inpr;
  logic        io_skip;
  logic        io_fgi;
  logic        io_fgo;
  logic        io_ien;
  logic        io_irq;
  logic [7:0]  io_outr;
  logic        io_din_valid;
  logic [7:0]  io_din_data;
  logic        io_din_ready;
  logic        io_dout_valid;
  logic [7:0]  io_dout_data;
  logic        io_dout_ready;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [7:0] out_q[$];
  logic [7:0] in_q[$];

  typedef struct {
    logic        iostb;
    logic [11:0] ir;
    logic        int_ack;
    logic        exp_skip;
    logic        exp_ien;
    logic        exp_irq;
  } vec_t;

  vec_t vecs[9];

  mano_io_ctrl #(.DATA_W(8), .FIFO_DEPTH(4)) dut (
    .io_clock      (io_clock),
    .io_reset      (io_reset),
    .io_iostb      (io_iostb),
    .io_ir         (io_ir),
    .io_ac         (io_ac),
    .io_int_ack    (io_int_ack),
    .io_inpr       (io_inpr),
    .io_skip       (io_skip),
    .io_fgi        (io_fgi),
    .io_fgo        (io_fgo),
    .io_ien        (io_ien),
    .io_irq        (io_irq),
    .io_outr       (io_outr),
    .io_din_valid  (io_din_valid),
    .io_din_data   (io_din_data),
    .io_din_ready  (io_din_ready),
    .io_dout_valid (io_dout_valid),
    .io_dout_data  (io_dout_data),
    .io_dout_ready (io_dout_ready)
  );

  initial io_clock = 1'b0;
  always #5 io_clock = ~io_clock;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic failNow(input string name, input string why);
    tests_run++;
    tests_failed++;
    $display("[TB] FAIL %s: %s", name, why);
  endtask

  // Drive one instruction cycle's inputs just after the falling edge
  task automatic applyStimulus(input logic iostb, input logic [11:0] ir,
                               input logic [7:0] ac, input logic int_ack);
    @(negedge io_clock);
    io_iostb   = iostb;
    io_ir      = ir;
    io_ac      = ac;
    io_int_ack = int_ack;
    #1;
  endtask

  task automatic finishCycle();
    @(posedge io_clock);
    #1;
    io_iostb   = 1'b0;
    io_ir      = '0;
    io_int_ack = 1'b0;
  endtask

  // Scoreboard pop for the output channel; ready must already be high
  task automatic popOut(input string name);
    logic [7:0] exp;
    checkOutput({name, "_valid"}, io_dout_valid, 1);
    if (io_dout_valid) begin
      if (out_q.size() == 0) begin
        failNow({name, "_data"}, "character offered with nothing expected");
      end else begin
        exp = out_q.pop_front();
        checkOutput({name, "_data"}, io_dout_data, exp);
      end
    end
  endtask

  task automatic sendReady(input string name);
    @(negedge io_clock);
    io_dout_ready = 1'b1;
    #1;
    popOut(name);
    @(posedge io_clock);
    #1;
    io_dout_ready = 1'b0;
  endtask

  // Offer one character from the input device, waiting a bounded time
  task automatic deviceSend(input logic [7:0] d);
    int n;
    n = 0;
    @(negedge io_clock);
    io_din_valid = 1'b1;
    io_din_data  = d;
    #1;
    while (!io_din_ready && n < 20) begin
      @(negedge io_clock);
      #1;
      n++;
    end
    if (!io_din_ready) begin
      failNow("din_accept", "din_ready stayed 0, expected 1");
      io_din_valid = 1'b0;
    end else begin
      @(posedge io_clock);
      #1;
      in_q.push_back(d);
      io_din_valid = 1'b0;
    end
  endtask

  // Compare INPR with the scoreboard, then execute INP
  task automatic readInp(input string name);
    logic [7:0] exp;
    if (in_q.size() == 0) begin
      failNow(name, "INP issued with no character expected");
    end else begin
      exp = in_q.pop_front();
      checkOutput(name, io_inpr, exp);
    end
    applyStimulus(1'b1, B_INP, 8'h00, 1'b0);
    finishCycle();
  endtask

  initial begin
    io_reset      = 1'b1;
    io_iostb      = 1'b0;
    io_ir         = '0;
    io_ac         = '0;
    io_int_ack    = 1'b0;
    io_din_valid  = 1'b0;
    io_din_data   = '0;
    io_dout_ready = 1'b0;

    //             iostb ir             ack   skip  ien   irq
    vecs[0] = '{1'b1, B_SKO,         1'b0, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{1'b1, B_SKI,         1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b0, B_SKO,         1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b1, B_SKI | B_SKO, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{1'b1, B_ION,         1'b0, 1'b0, 1'b1, 1'b1};
    vecs[5] = '{1'b1, B_ION | B_IOF, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{1'b0, B_ION,         1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{1'b1, B_ION | B_SKO, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[8] = '{1'b1, B_ION,         1'b1, 1'b0, 1'b0, 1'b0};

    repeat (2) @(posedge io_clock);
    #1;
    io_reset = 1'b0;

    // Reset state
    checkOutput("rst_fgo", io_fgo, 1);
    checkOutput("rst_fgi", io_fgi, 0);
    checkOutput("rst_ien", io_ien, 0);
    checkOutput("rst_irq", io_irq, 0);
    checkOutput("rst_dout_valid", io_dout_valid, 0);
    checkOutput("rst_din_ready", io_din_ready, 1);
    checkOutput("rst_outr", io_outr, 0);
    checkOutput("rst_inpr", io_inpr, 0);

    // Vector table: skip decode and IEN priority from the idle state
    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].iostb, vecs[i].ir, 8'h00, vecs[i].int_ack);
      checkOutput($sformatf("vec%0d_skip", i), io_skip, vecs[i].exp_skip);
      finishCycle();
      checkOutput($sformatf("vec%0d_ien", i), io_ien, vecs[i].exp_ien);
      checkOutput($sformatf("vec%0d_irq", i), io_irq, vecs[i].exp_irq);
    end

    // OUT 8'h05 with the device stalled for 10 cycles
    applyStimulus(1'b1, B_OUT, 8'h05, 1'b0);
    out_q.push_back(8'h05);
    finishCycle();
    checkOutput("out_valid", io_dout_valid, 1);
    checkOutput("out_fgo", io_fgo, 0);
    checkOutput("out_outr", io_outr, 8'h05);
    for (int i = 0; i < 10; i++) begin
      applyStimulus((i == 4) ? 1'b1 : 1'b0, B_OUT, 8'h41, 1'b0);
      finishCycle();
      checkOutput($sformatf("send%0d_data", i), io_dout_data, 8'h05);
      checkOutput($sformatf("send%0d_fgo", i), io_fgo, 0);
    end
    checkOutput("send_outr_kept", io_outr, 8'h05);
    sendReady("out1");
    checkOutput("out1_done_fgo", io_fgo, 1);
    checkOutput("out1_done_valid", io_dout_valid, 0);

    // Minimum turnaround with ready already high
    @(negedge io_clock);
    io_dout_ready = 1'b1;
    applyStimulus(1'b1, B_OUT, 8'h22, 1'b0);
    out_q.push_back(8'h22);
    finishCycle();
    checkOutput("turn_fgo0", io_fgo, 0);
    @(negedge io_clock);
    #1;
    popOut("turn");
    @(posedge io_clock);
    #1;
    checkOutput("turn_fgo1", io_fgo, 1);
    checkOutput("turn_valid0", io_dout_valid, 0);
    io_dout_ready = 1'b0;

    // Input character 60, INP, then 50
    deviceSend(8'd60);
    checkOutput("in60_fgi", io_fgi, 1);
    checkOutput("in60_inpr", io_inpr, 8'h3C);
`ifdef MANO_IO_INFIFO_EN
    checkOutput("in60_din_ready", io_din_ready, 1);
`else
    checkOutput("in60_din_ready", io_din_ready, 0);
`endif
    readInp("in60_read");
    checkOutput("inp_fgi0", io_fgi, 0);
    checkOutput("inp_din_ready", io_din_ready, 1);
`ifdef MANO_IO_INFIFO_EN
`else
    checkOutput("inp_inpr_kept", io_inpr, 8'h3C);
    applyStimulus(1'b1, B_INP, 8'h00, 1'b0);
    finishCycle();
    checkOutput("inp_empty_fgi", io_fgi, 0);
    checkOutput("inp_empty_inpr", io_inpr, 8'h3C);
`endif
    deviceSend(8'd50);
    checkOutput("in50_inpr", io_inpr, 8'h32);
    readInp("in50_read");

    // Interrupts: ION, then block FGO with an OUT, then FGI raises irq
    applyStimulus(1'b1, B_ION, 8'h00, 1'b0);
    finishCycle();
    checkOutput("ion_irq_fgo", io_irq, 1);
    applyStimulus(1'b1, B_OUT, 8'h11, 1'b0);
    out_q.push_back(8'h11);
    finishCycle();
    checkOutput("irq_no_flags", io_irq, 0);
    deviceSend(8'h55);
    checkOutput("irq_fgi", io_irq, 1);
    applyStimulus(1'b1, B_ION, 8'h00, 1'b1);
    checkOutput("ack_ski_skip", io_skip, 0);
    finishCycle();
    checkOutput("ack_ien", io_ien, 0);
    checkOutput("ack_irq", io_irq, 0);

    // Reset during SEND with IEN and FGI set
    applyStimulus(1'b1, B_ION | B_SKI, 8'h00, 1'b0);
    checkOutput("ski_skip", io_skip, 1);
    finishCycle();
    checkOutput("pre_rst_ien", io_ien, 1);
    checkOutput("pre_rst_valid", io_dout_valid, 1);
    @(negedge io_clock);
    io_reset = 1'b1;
    @(posedge io_clock);
    #1;
    io_reset = 1'b0;
    out_q.delete();
    in_q.delete();
    checkOutput("midrst_valid", io_dout_valid, 0);
    checkOutput("midrst_fgo", io_fgo, 1);
    checkOutput("midrst_ien", io_ien, 0);
    checkOutput("midrst_fgi", io_fgi, 0);
    checkOutput("midrst_outr", io_outr, 0);

`ifdef MANO_IO_INFIFO_EN
    // Fill the FIFO
    for (int v = 1; v <= 4; v++) begin
      deviceSend(8'(v));
    end
    checkOutput("fifo_full_ready", io_din_ready, 0);
    checkOutput("fifo_full_fgi", io_fgi, 1);

    // INP while the device offers 5: pop now, push once space frees up
    @(negedge io_clock);
    io_din_valid = 1'b1;
    io_din_data  = 8'd5;
    io_iostb     = 1'b1;
    io_ir        = B_INP;
    #1;
    checkOutput("fifo_pop1", io_inpr, in_q.pop_front());
    finishCycle();
    checkOutput("fifo_after_pop_ready", io_din_ready, 1);
    @(posedge io_clock);
    #1;
    in_q.push_back(8'd5);
    io_din_valid = 1'b0;
    checkOutput("fifo_refull_ready", io_din_ready, 0);
    for (int k = 0; k < 4; k++) begin
      readInp($sformatf("fifo_drain%0d", k));
    end
    checkOutput("fifo_drained_fgi", io_fgi, 0);
    checkOutput("fifo_drained_ready", io_din_ready, 1);

    // Simultaneous push and pop keep the count at one
    deviceSend(8'd7);
    @(negedge io_clock);
    io_din_valid = 1'b1;
    io_din_data  = 8'd8;
    io_iostb     = 1'b1;
    io_ir        = B_INP;
    #1;
    checkOutput("fifo_pp_head", io_inpr, in_q.pop_front());
    finishCycle();
    in_q.push_back(8'd8);
    io_din_valid = 1'b0;
    checkOutput("fifo_pp_fgi", io_fgi, 1);
    readInp("fifo_pp_read");
    checkOutput("fifo_pp_empty", io_fgi, 0);

    // Pop when empty is ignored
    applyStimulus(1'b1, B_INP, 8'h00, 1'b0);
    finishCycle();
    checkOutput("fifo_empty_pop_fgi", io_fgi, 0);
    checkOutput("fifo_empty_pop_ready", io_din_ready, 1);
`endif

    if (out_q.size() != 0 || in_q.size() != 0) begin
      failNow("scoreboard_leftover", "expected characters never observed");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mano_io_ctrl.md
# mano_io_ctrl

Character I/O controller for the Mano machine. It sits between the CPU's register-I/O instruction decode and the external input and output character devices. It owns INPR/OUTR, the FGI/FGO/IEN flags and the interrupt request, and it sequences valid/ready handshakes to both devices. This replaces the bare flag-set pins with a proper device protocol.

## Interface
Parameters:
- DATA_W, 8, character width (INPR/OUTR/AC low bits)
- FIFO_DEPTH, 4, input FIFO entries; power of two ≥2; used only with MANO_IO_INFIFO_EN

Ports:
- io_clock  in  1  single clock, all state on rising edge
- io_reset  in  1  synchronous, active-high reset
- io_iostb  in  1  one-cycle strobe: a register-I/O instruction executes this cycle
- io_ir  in  12  IR[11:0]; bit 11 INP, 10 OUT, 9 SKI, 8 SKO, 7 ION, 6 IOF
- io_ac  in  DATA_W  AC[7:0], source for OUT
- io_int_ack  in  1  CPU entered interrupt cycle (R); clears IEN
- io_inpr  out  DATA_W  current input character (head of FIFO when enabled)
- io_skip  out  1  combinational: io_iostb & ((ir[9]&fgi)|(ir[8]&fgo))
- io_fgi, io_fgo, io_ien  out  1  flag registers
- io_irq  out  1  ien & (fgi | fgo), registered-flag based, combinational
- io_outr  out  DATA_W  OUTR register
- io_din_valid  in  1 / io_din_data  in  DATA_W / io_din_ready  out  1  input device channel
- io_dout_valid  out  1 / io_dout_data  out  DATA_W / io_dout_ready  in  1  output device channel

## Operation
- Reset values: fgi=0, fgo=1, ien=0, outr=0, inpr=0, dout_valid=0, din_ready=1, irq=0, FIFO empty, output FSM IDLE.
- Output FSM, two states:
  - IDLE (fgo=1, dout_valid=0). On iostb&ir[10]: outr←io_ac, fgo←0, go to SEND.
  - SEND (dout_valid=1, dout_data=outr held stable). On dout_ready: fgo←1, go to IDLE.
  - OUT while in SEND is ignored; outr is unchanged (program violated SKO protocol).
- Input, no FIFO: din_ready = !fgi. Accept (din_valid&din_ready) → inpr←din_data, fgi←1. iostb&ir[11] → fgi←0; inpr keeps its value. INP with fgi=0: fgi stays 0, inpr is unchanged.
- IEN: ir[7] sets, ir[6] clears, io_int_ack clears. Priority: int_ack > IOF > ION.
- Multiple ir bits in one strobe: each acts independently, subject to the IEN priority above.
- ir bits are ignored when io_iostb=0.
- Reset mid-transfer: dout_valid drops the next cycle and the character is abandoned. The device must tolerate valid being withdrawn only on reset.

## Timing
- OUT strobed in cycle N: dout_valid=1, fgo=0, outr=AC from N+1.
- Transfer completes when ready is sampled high at edge M; from M+1 fgo=1 and dout_valid=0. Minimum OUT-to-fgo turnaround is 2 cycles.
- Input accepted at edge N: fgi=1 and inpr valid from N+1. INP at N: fgi=0 from N+1.
- io_skip and io_irq are zero-latency, derived from current registered flags.

## Configuration
- MANO_IO_INFIFO_EN defined: a FIFO_DEPTH input FIFO sits behind INPR.
  - din_ready = !full; fgi = !empty; io_inpr = head; INP pops.
  - A push and a pop in the same cycle are both performed and the count is unchanged.
  - Push when full cannot occur (ready low). Pop when empty is ignored.
- Undefined: single INPR register exactly as described in Operation.

## Structure
- Package mano_io_pkg holds:
  - output FSM state enum (OST_IDLE, OST_SEND)
  - IR bit-position constants IR_INP=11, IR_OUT=10, IR_SKI=9, IR_SKO=8, IR_ION=7, IR_IOF=6
  - DATA_W default
- Sub-module mano_io_fifo (sync FIFO with push/pop/full/empty/head), instantiated only under MANO_IO_INFIFO_EN.

## Test plan
- Reset, then idle: fgo=1, fgi=0, ien=0, irq=0, dout_valid=0, din_ready=1; SKO strobe → io_skip=1; SKI strobe → io_skip=0.
- OUT with AC=8'h05; hold dout_ready=0 for 10 cycles, then pulse it → dout_data=8'h05 stable throughout, fgo=0 during SEND, fgo=1 one cycle after the ready edge; a second OUT of 8'h41 issued mid-SEND is dropped and outr stays 8'h05.
- Device sends 60 → fgi=1, inpr=8'h3C, din_ready=0 (no FIFO); INP → fgi=0; device then sends 50 → inpr=8'h32.
- ION, then device sends a char → irq=1; int_ack together with ION in the same cycle → ien=0, irq=0.
- With MANO_IO_INFIFO_EN and depth 4: push 1,2,3,4 → din_ready=0; INP and a push of 5 in the same cycle → pops 1 and fills to 4 again; drain all → reads 2,3,4,5, then fgi=0.
- Assert reset during SEND → next cycle dout_valid=0, fgo=1, and ien/fgi are cleared.
